// File: rtl/fpu_div_arbiter.sv
// Round-robin sequencer sharing one multicycle single-precision divider between two requesters.
// Optional error statistics counter enabled by defining FPU_DIV_ARB_STATS_EN.
module fpu_div_arbiter #(
    parameter int unsigned DIV_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [3:0]  req_round_mode,
    output logic [1:0]  resp_valid,
    input  logic [1:0]  resp_ready,
    output logic [31:0] resp_result,
    output logic        resp_error,
    output logic        resp_overflow,
    output logic        busy,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic [1:0]  div_round_mode,
    input  logic [31:0] div_result,
    input  logic        div_error,
    input  logic        div_overflow
`ifdef FPU_DIV_ARB_STATS_EN
    ,
    output logic [15:0] err_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state, state_nxt;
    logic        owner;
    logic        prio;
    logic [3:0]  cnt;
    logic        grant;
    logic        accept;
    logic        resp_hs;

    // A tie goes to prio; a lone request wins outright.
    always_comb begin
        grant     = (req_valid == 2'b11) ? prio : req_valid[1];
        accept    = (state == IDLE) && (req_valid != 2'b00);
        resp_hs   = (state == RESP) && resp_ready[owner];
        req_ready = '0;
        if (accept)
            req_ready[grant] = 1'b1;
        resp_valid = '0;
        if (state == RESP)
            resp_valid[owner] = 1'b1;
        busy = (state != IDLE);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    if (resp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            owner          <= 1'b0;
            prio           <= 1'b0;
            cnt            <= '0;
            div_a          <= '0;
            div_b          <= '0;
            div_round_mode <= '0;
            resp_result    <= '0;
            resp_error     <= 1'b0;
            resp_overflow  <= 1'b0;
        end else begin
            if (accept) begin
                div_a          <= grant ? req_a[63:32] : req_a[31:0];
                div_b          <= grant ? req_b[63:32] : req_b[31:0];
                div_round_mode <= grant ? req_round_mode[3:2] : req_round_mode[1:0];
                owner          <= grant;
                prio           <= ~grant;
                cnt            <= 4'(DIV_LATENCY - 1);
            end
            if (state == WAIT) begin
                if (cnt != '0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    resp_result   <= div_result;
                    resp_error    <= div_error;
                    resp_overflow <= div_overflow;
                end
            end
        end
    end

`ifdef FPU_DIV_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n)
            err_count <= '0;
        else if (resp_hs && resp_error && (err_count != '1))
            err_count <= err_count + 16'd1;
    end
`endif

endmodule

// File: doc/fpu_div_arbiter.md
# fpu_div_arbiter

Sequencer that shares one IEEE-754 single-precision divider datapath between two requesters. It accepts operand/rounding-mode requests over valid/ready handshakes and arbitrates round-robin. It holds the divider inputs stable for a configurable multicycle settling window, captures result/error/overflow, and returns them to the owning requester over a second valid/ready handshake. It sits between the FPU issue logic and the combinational divider instance.

## Interface
- `DIV_LATENCY`, default 2: cycles the divider inputs are held before its outputs are sampled; legal range 1..15.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `req_valid` in 2: per-requester request valid; bit i belongs to requester i.
- `req_ready` out 2: per-requester request accept.
- `req_a` in 64: dividends, {r1, r0}, 32 bits each.
- `req_b` in 64: divisors, {r1, r0}.
- `req_round_mode` in 4: rounding modes, {r1, r0}, 2 bits each.
- `resp_valid` out 2: per-requester response valid.
- `resp_ready` in 2: per-requester response accept.
- `resp_result` out 32: quotient, shared by both requesters; meaningful only under the asserted `resp_valid` bit.
- `resp_error` out 1: divider error flag (NaN/divide-by-zero).
- `resp_overflow` out 1: divider overflow flag.
- `busy` out 1: high in any state other than IDLE.
- `div_a` out 32, `div_b` out 32, `div_round_mode` out 2: registered divider inputs.
- `div_result` in 32, `div_error` in 1, `div_overflow` in 1: divider outputs.
- `err_count` out 16: present only with `FPU_DIV_ARB_STATS_EN`; see Configuration.

## Operation
- **States:** IDLE, WAIT, RESP. `owner` register, 1 bit. `prio` register, 1 bit: the requester favoured on a tie.
- **IDLE, grant:**
  - If exactly one `req_valid` bit is set, grant that requester.
  - If both are set, grant requester `prio`.
  - `req_ready` is combinational: the granted requester's bit is set, and only in IDLE. It is never set for both requesters.
- **IDLE, on accept:**
  - Register the granted requester's a/b/round_mode into `div_*`.
  - Set `owner` to the granted requester and `prio` to the other requester.
  - Load `cnt` = DIV_LATENCY-1 and go to WAIT.
- **WAIT:**
  - `div_*` stay stable.
  - If `cnt`≠0, decrement it.
  - If `cnt`=0, capture `div_result`/`div_error`/`div_overflow` into the response registers and go to RESP.
- **RESP:**
  - `resp_valid[owner]`=1. The response registers are held unchanged until `resp_ready[owner]`=1.
  - On that handshake, go to IDLE.
  - `resp_ready[~owner]` is ignored.
- **Register stability:** `div_*` keep their last value outside WAIT and change only on accept.
- **Response data:** `resp_*` data outputs are registered and hold their last captured value after the handshake.

## Timing
- **Reset values:** all outputs 0. State=IDLE, `prio`=0, `owner`=0, `cnt`=0, `err_count`=0.
- **Per-operation timeline, request accepted at edge T (both valid and ready):**
  - `div_*` are valid from T+1.
  - The result is sampled at edge T+DIV_LATENCY.
  - `resp_valid` is high from T+DIV_LATENCY, i.e. during the cycle after that edge.
- **Throughput:**
  - The earliest next accept is in the cycle after the response handshake, since IDLE is re-entered then.
  - With `resp_ready` held high, back-to-back accepts are DIV_LATENCY+2 cycles apart.
- **Simultaneous events:**
  - A new request arriving during WAIT/RESP waits with `req_ready`=0. Its requester must hold valid and data stable.
  - `resp_ready` asserted before `resp_valid` has no effect.
- **Reset mid-operation:** `reset_n`=0 at any edge aborts the operation with no response. Everything returns to reset values.
- **Fairness:** with both requesters continuously valid, grants alternate 0,1,0,1…

## Configuration
- **`FPU_DIV_ARB_STATS_EN` defined:**
  - Port `err_count` exists.
  - It increments by 1 at each response handshake whose `resp_error`=1.
  - It saturates at 16'hFFFF and resets to 0.
- **`FPU_DIV_ARB_STATS_EN` undefined:** the port and counter are absent, and all other behaviour is identical.

## Test plan
The bench drives `div_*` inputs from a stub model: result = a^b; error = (b==0); overflow = a[0]. DIV_LATENCY=2 unless stated.

- **Single request:** r0 sends a=0x40C00000, b=0x40000000, mode=00, with resp_ready=1.
  - Required: `req_ready[0]` in the same cycle.
  - Required: `resp_valid[0]` exactly 2 cycles after the accept edge, with result=0x00C00000, error=0, overflow=0.
- **Simultaneous requests after reset:** both valid, r0 a=0x1, b=0x3; r1 a=0x2, b=0x0.
  - Required: r0 is granted first, with result 0x2 and overflow=1.
  - Required: r1 is granted next, with result 0x2 and error=1.
  - Required: accepts are 4 cycles apart.
- **Response backpressure:** hold `resp_ready[0]`=0 for 5 cycles.
  - Required: `resp_valid[0]` and `resp_result` remain stable, `req_ready`=00 throughout, and the response completes on the first cycle `resp_ready` goes high.
- **Reset mid-operation:** assert `reset_n`=0 for 1 cycle during WAIT.
  - Required: no `resp_valid`, all outputs 0, `busy`=0; the next request is handled normally.
- **Latency parameter, stats build:** DIV_LATENCY=5 with `FPU_DIV_ARB_STATS_EN`; three divides by b=0.
  - Required: each `resp_valid` is 5 cycles after its accept.
  - Required: `err_count`=3.
  - Required: with `err_count` forced near the top value by preload stimulus, it saturates at 0xFFFF.
